// File: rtl/uart_tx_scheduler_pkg.sv
// Shared data types for the UART transmit scheduler: scalar/byte aliases and the FSM state enum.
package uart_tx_scheduler_pkg;

  typedef logic       bit_t;
  typedef logic [7:0] uint8_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    SENDING = 2'd2,
    GAP     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// uart_req_arbiter: combinational winner selection, searching from ptr upward and wrapping.
// With ptr tied to zero this degenerates to fixed lowest-index priority.
module uart_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos     = (int'(ptr) + i) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters: grant, launch, wait for frame, one-cycle gap.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration; default build is fixed lowest-index priority.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LAUNCH_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    tx_transmit,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    sched_busy,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LAUNCH_TIMEOUT);

  sched_state_t       state_reg, state_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] winner_reg, winner_next;
  uint8_t             data_reg, data_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  bit_t               terr_reg, terr_next;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_ptr;

`ifdef UART_TX_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  assign arb_ptr = ptr_reg;
`else
  assign arb_ptr = '0;
`endif

  uart_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arbiter (
    .req   (req),
    .ptr   (arb_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ack_reg    <= '0;
      done_reg   <= '0;
      winner_reg <= '0;
      data_reg   <= 8'h00;
      cnt_reg    <= '0;
      terr_reg   <= 1'b0;
`ifdef UART_TX_SCHED_RR_EN
      ptr_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      ack_reg    <= ack_next;
      done_reg   <= done_next;
      winner_reg <= winner_next;
      data_reg   <= data_next;
      cnt_reg    <= cnt_next;
      terr_reg   <= terr_next;
`ifdef UART_TX_SCHED_RR_EN
      ptr_reg    <= ptr_next;
`endif
    end
  end

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next  = state_reg;
    ack_next    = '0;
    done_next   = '0;
    winner_next = winner_reg;
    data_next   = data_reg;
    cnt_next    = cnt_reg;
    terr_next   = 1'b0;
`ifdef UART_TX_SCHED_RR_EN
    ptr_next    = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if ((|req) && !tx_busy) begin
          state_next  = LAUNCH;
          ack_next    = arb_grant;
          winner_next = arb_grant;
          data_next   = req_data[arb_idx];
          cnt_next    = '0;
`ifdef UART_TX_SCHED_RR_EN
          ptr_next    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
`endif
        end
      end
      LAUNCH: begin
        // Counter stops at LAUNCH_TIMEOUT since the state is left on that same edge.
        cnt_next = cnt_inc;
        if (tx_busy) begin
          state_next = SENDING;
        end else if (cnt_inc == TIMEOUT_VAL) begin
          terr_next  = 1'b1;
          done_next  = winner_reg;
          state_next = GAP;
        end
      end
      SENDING: begin
        if (!tx_busy) begin
          done_next  = winner_reg;
          state_next = GAP;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state register so reset drops them without waiting for a clock.
  assign tx_transmit = (state_reg == LAUNCH);
  assign sched_busy  = (state_reg != IDLE);
  assign req_ack     = ack_reg;
  assign req_done    = done_reg;
  assign tx_data     = data_reg;
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed scenarios push expected grants, a monitor checks them.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;

  typedef struct {
    int       idx;
    int       data;
    int       launch;
    bit       timeout;
    int       gap;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ-1:0][7:0] req_data = '0;
  logic [NUM_REQ-1:0]      req_ack;
  logic [NUM_REQ-1:0]      req_done;
  logic                    tx_transmit;
  logic [7:0]              tx_data;
  logic                    tx_busy = 1'b0;
  logic                    sched_busy;
  logic                    timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int busy_delay = 3;
  int frame_len = 20;
  int launch_ctr = 0;
  int rem = 0;
  int busy_fall_cyc = 0;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid = 0;
  int   launch_cnt = 0;
  int   last_ack_cyc = 0;
  bit   prev_tx = 0;
  bit   seen_high = 0;
  int   low_run = 0;

  uart_tx_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .LAUNCH_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .req_done    (req_done),
    .tx_transmit (tx_transmit),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input int data, input int launch, input bit to, input int gap);
    exp_t e;
    e.idx = idx; e.data = data; e.launch = launch; e.timeout = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Transmitter model: raises busy after busy_delay launch cycles (0 = never), holds it frame_len cycles.
  always @(negedge clk) begin
    if (tx_transmit) launch_ctr++; else launch_ctr = 0;
    if (tx_busy) begin
      rem--;
      if (rem == 0) begin
        tx_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end else if (tx_transmit && busy_delay != 0 && launch_ctr == busy_delay) begin
      tx_busy = 1'b1;
      rem = frame_len;
    end
  end

  // Monitor: compares every ack/done the DUT presents against the scoreboard queue.
  always @(negedge clk) begin
    if (reset) begin
      cur_valid = 0;
      seen_high = 0;
      prev_tx = 0;
      low_run = 0;
    end else begin
      if (req_ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", int'(req_ack), 0);
        end else begin
          cur = exp_q.pop_front();
          chk("ack_onehot", int'(req_ack), 1 << cur.idx);
          chk("ack_tx_data", int'(tx_data), cur.data);
          if (cur.gap > 0) chk("ack_spacing", cyc - last_ack_cyc, cur.gap);
          last_ack_cyc = cyc;
          cur_valid = 1;
          launch_cnt = 0;
        end
      end
      if (tx_transmit) begin
        launch_cnt++;
        if (!prev_tx && seen_high) chk("tx_low_gap_ge2", int'(low_run >= 2), 1);
        seen_high = 1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_tx = tx_transmit;
      if (req_done != '0) begin
        if (!cur_valid) begin
          chk("unexpected_done", int'(req_done), 0);
        end else begin
          chk("done_onehot", int'(req_done), 1 << cur.idx);
          chk("launch_cycles", launch_cnt, cur.launch);
          chk("timeout_err", int'(timeout_err), int'(cur.timeout));
          chk("tx_data_stable", int'(tx_data), cur.data);
          if (!cur.timeout) chk("done_after_busy_fall", cyc - busy_fall_cyc, 1);
          $display("txn req=%0d data=0x%02h launch=%0d timeout=%0d", cur.idx, cur.data, launch_cnt, timeout_err);
          cur_valid = 0;
        end
      end else if (timeout_err) begin
        chk("timeout_without_done", int'(timeout_err), 0);
      end
    end
  end

  task automatic wait_ack(output logic [NUM_REQ-1:0] got);
    got = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        got = req_ack;
        return;
      end
    end
    chk("wait_ack_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_done != '0) return;
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_quiet();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!sched_busy && !tx_busy) return;
    end
    chk("wait_quiet_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [NUM_REQ-1:0] got;
    #2;
    chk("rst_req_ack", int'(req_ack), 0);
    chk("rst_req_done", int'(req_done), 0);
    chk("rst_tx_transmit", int'(tx_transmit), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_sched_busy", int'(sched_busy), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single request on requester 2.
    busy_delay = 3; frame_len = 20;
    req_data[2] = 8'hA5;
    push(2, 8'hA5, 3, 0, -1);
    @(negedge clk);
    req[2] = 1'b1;
    wait_ack(got);
    req[2] = 1'b0;
    wait_done();
    wait_quiet();

    // Contention.
    do_reset();
    busy_delay = 2; frame_len = 6;
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = 8'(8'h30 + i);
`ifdef UART_TX_SCHED_RR_EN
    push(0, 8'h30, 2, 0, -1);
    push(1, 8'h31, 2, 0, 10);
    push(2, 8'h32, 2, 0, 10);
    push(3, 8'h33, 2, 0, 10);
    push(0, 8'h30, 2, 0, 10);
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ack(got);
    req = 4'b0000;
`else
    push(1, 8'h31, 2, 0, -1);
    push(1, 8'h31, 2, 0, 10);
    push(1, 8'h31, 2, 0, 10);
    push(2, 8'h32, 2, 0, 10);
    @(negedge clk);
    req = 4'b0110;
    for (int k = 0; k < 3; k++) wait_ack(got);
    req[1] = 1'b0;
    wait_ack(got);
    req[2] = 1'b0;
`endif
    wait_done();
    wait_quiet();

    // Launch timeout: transmitter never goes busy.
    do_reset();
    busy_delay = 0;
    req_data[0] = 8'h5C;
    push(0, 8'h5C, 16, 1, -1);
    @(negedge clk);
    req[0] = 1'b1;
    wait_ack(got);
    req[0] = 1'b0;
    wait_done();
    @(negedge clk);
    chk("idle_after_gap", int'(sched_busy), 0);
    wait_quiet();

    // Reset while SENDING, then pending requester 3 served normally.
    busy_delay = 2; frame_len = 20;
    req_data[3] = 8'hC3;
    push(3, 8'hC3, 2, 0, -1);
    @(negedge clk);
    req[3] = 1'b1;
    wait_ack(got);
    repeat (5) @(negedge clk);
    chk("pre_rst_sched_busy", int'(sched_busy), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_sched_busy", int'(sched_busy), 0);
    chk("mid_rst_tx_data", int'(tx_data), 0);
    chk("mid_rst_tx_transmit", int'(tx_transmit), 0);
    chk("mid_rst_req_done", int'(req_done), 0);
    chk("mid_rst_req_ack", int'(req_ack), 0);
    push(3, 8'hC3, 2, 0, -1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_ack(got);
    req[3] = 1'b0;
    wait_done();
    wait_quiet();

    // Back-to-back: new request raised in the done cycle.
    busy_delay = 2; frame_len = 4;
    req_data[0] = 8'h11; req_data[1] = 8'h22;
    push(0, 8'h11, 2, 0, -1);
    push(1, 8'h22, 2, 0, 8);
    @(negedge clk);
    req[0] = 1'b1;
    wait_ack(got);
    req[0] = 1'b0;
    wait_done();
    req[1] = 1'b1;
    wait_ack(got);
    req[1] = 1'b0;
    wait_done();
    wait_quiet();

    repeat (5) @(negedge clk);
    chk("sb_pending", exp_q.size(), 0);
    chk("sb_open_txn", int'(cur_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
